fifo_transfer_scheduler: RTL and testbench
==========================================

Name: fifo_transfer_scheduler

Overview:
- Sequences the interface FIFO between four requesters: ifmap load, filter load and bias load (DRAM -> GLB), and psum writeback (GLB -> DRAM).
- Arbitrates pending requests, programs path and destination selects, pulses transfer to load the base address, issues per-word reads throttled by wfull, counts drained words, and signals completion.
- Sits between the top-level layer controller and the FIFO interface unit, in the core_clk domain.

Parameters:
ADDR_WIDTH, 20, GLB/DRAM word address width
LEN_WIDTH, 16, transfer length (words) width

Ports:
core_clk  in  1  core clock; all state on rising edge
core_reset  in  1  asynchronous, active-low reset
req_ifmap / req_filter / req_bias / req_wb  in  1 each  request; held high until the matching done pulse
addr_ifmap / addr_filter / addr_bias / addr_wb  in  ADDR_WIDTH each  base address per requester
len_ifmap / len_filter / len_bias / len_wb  in  LEN_WIDTH each  word count per requester
wfull  in  1  FIFO write-side full
drain_ack  in  1  one-cycle pulse per word leaving the FIFO read side (GLB write or DRAM write)
done_ifmap / done_filter / done_bias / done_wb  out  1 each  one-cycle completion pulse
direct_back_path  out  1  1 = writeback path (GLB -> DRAM)
ifmap_filter  out  2  00 ifmap, 10 filter, 01 bias
ifmap_bias  out  1  1 for ifmap, 0 otherwise
base_address  out  ADDR_WIDTH  registered base of the granted request
transfer  out  1  one-cycle address-generator load pulse
read_from_dram  out  1  word-read issue, load path
read_from_glb  out  1  word-read issue, writeback path
rinc_to_glb  out  1  FIFO pop enable, load path
rinc_to_dram  out  1  FIFO pop enable, writeback path
dram_w_en  out  1  DRAM write enable, writeback path
busy  out  1  state != IDLE

Behaviour:
- Reset (core_reset low, asynchronous): state IDLE. All outputs 0 except ifmap_filter=00. Round-robin pointer = ifmap. Both counters 0.
- States:
  - IDLE -> GRANT when any req is high.
  - GRANT -> SETUP.
  - SETUP -> RUN.
  - RUN -> DRAIN when issued == len.
  - DRAIN -> DONE when drained == len.
  - DONE -> IDLE.
- Arbitration (in IDLE):
  - req_wb has absolute priority.
  - Otherwise round-robin over ifmap -> filter -> bias, starting at the pointer.
  - Pointer advances to the entry after the granted load when that load reaches DONE; writeback does not move the pointer.
- GRANT:
  - Latches the grant id, addr and len, and clears both counters.
  - Drives direct_back_path, ifmap_filter and ifmap_bias from the grant id. These stay constant until IDLE.
  - len == 0: goes straight to DONE. No transfer pulse, no reads.
- SETUP: transfer = 1 for exactly this one cycle; base_address is already valid.
- RUN:
  - issue = (issued < len) & ~wfull, combinational on registered state.
  - issue drives read_from_dram (load) or read_from_glb (writeback).
  - issued increments on issue.
  - wfull high stalls issue with no count change.
- RUN and DRAIN:
  - rinc_to_glb (load) or rinc_to_dram together with dram_w_en (writeback) stay high while drained < len.
  - drained increments on each drain_ack.
  - drain_ack when drained == len is ignored (saturates, no wrap).
- Simultaneous issue and drain_ack in one cycle: both counters update.
- DONE: the matching done_* is high for one cycle. Earliest next grant is the cycle after DONE, i.e. back-to-back requests are separated by one IDLE cycle.
- Requests that drop before grant are not served. req changes after grant are ignored until DONE.
- Counters are LEN_WIDTH bits; len = 2^LEN_WIDTH-1 must complete without overflow.
- Reset asserted mid-transfer: immediate return to reset values, no done pulse.
- Latency, len = N with no stalls: req rising -> transfer 2 cycles later; first read the following cycle; done no earlier than N+3 cycles after grant.

Test Plan:
1. Single ifmap load, len=4, addr=0x00100, wfull=0, drain_ack one cycle after each read -> ifmap_filter=00, ifmap_bias=1, one transfer pulse, exactly 4 read_from_dram, one done_ifmap.
2. Filter load len=8 with wfull high for 3 cycles mid-RUN -> read_from_dram low during stall, exactly 8 reads total, done_filter after 8th drain_ack.
3. req_ifmap, req_filter, req_bias, req_wb all high at once -> service order wb, ifmap, filter, bias; each done pulses once; direct_back_path=1 only during wb, with read_from_glb, rinc_to_dram and dram_w_en active.
4. Bias load len=0 -> done_bias 2 cycles after grant, no transfer, no reads; ifmap_filter=01, ifmap_bias=0 while busy.
5. core_reset low during RUN of an 8-word filter load after 3 reads -> all outputs return to reset values asynchronously, no done_filter; after release, a held req_filter restarts with a fresh transfer and 8 reads.
6. Extra drain_ack after drained == len in DRAIN -> counter holds at len, single done pulse, next state IDLE.

Source files
------------

// File: rtl/fifo_transfer_scheduler.sv
// Schedules interface-FIFO transfers for ifmap/filter/bias loads and psum writeback:
// arbitration, path selects, address-load pulse, throttled word issue and drain counting.
module fifo_transfer_scheduler #(
  parameter int ADDR_WIDTH = 20,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  core_clk,
  input  logic                  core_reset,
  input  logic                  req_ifmap,
  input  logic                  req_filter,
  input  logic                  req_bias,
  input  logic                  req_wb,
  input  logic [ADDR_WIDTH-1:0] addr_ifmap,
  input  logic [ADDR_WIDTH-1:0] addr_filter,
  input  logic [ADDR_WIDTH-1:0] addr_bias,
  input  logic [ADDR_WIDTH-1:0] addr_wb,
  input  logic [LEN_WIDTH-1:0]  len_ifmap,
  input  logic [LEN_WIDTH-1:0]  len_filter,
  input  logic [LEN_WIDTH-1:0]  len_bias,
  input  logic [LEN_WIDTH-1:0]  len_wb,
  input  logic                  wfull,
  input  logic                  drain_ack,
  output logic                  done_ifmap,
  output logic                  done_filter,
  output logic                  done_bias,
  output logic                  done_wb,
  output logic                  direct_back_path,
  output logic [1:0]            ifmap_filter,
  output logic                  ifmap_bias,
  output logic [ADDR_WIDTH-1:0] base_address,
  output logic                  transfer,
  output logic                  read_from_dram,
  output logic                  read_from_glb,
  output logic                  rinc_to_glb,
  output logic                  rinc_to_dram,
  output logic                  dram_w_en,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, GRANT, SETUP, RUN, DRAIN, DONE} state_t;

  localparam logic [1:0] ID_IFMAP  = 2'd0;
  localparam logic [1:0] ID_FILTER = 2'd1;
  localparam logic [1:0] ID_BIAS   = 2'd2;
  localparam logic [1:0] ID_WB     = 2'd3;

  state_t                 state, next_state;
  logic [1:0]             grant_id, rr_ptr, arb_id;
  logic [1:0]             cand0, cand1, cand2;
  logic                   arb_valid;
  logic [2:0]             req_load;
  logic [ADDR_WIDTH-1:0]  arb_addr;
  logic [LEN_WIDTH-1:0]   arb_len, len_q, issued, drained;
  logic                   issue, drain_en, is_wb;

  function automatic logic [1:0] next_load(input logic [1:0] id);
    return (id == ID_BIAS) ? ID_IFMAP : id + 2'd1;
  endfunction

  // Writeback wins outright; loads rotate starting at the round-robin pointer.
  always_comb begin
    req_load  = {req_bias, req_filter, req_ifmap};
    cand0     = rr_ptr;
    cand1     = next_load(cand0);
    cand2     = next_load(cand1);
    arb_valid = 1'b1;
    arb_id    = ID_WB;
    if (req_wb)              arb_id = ID_WB;
    else if (req_load[cand0]) arb_id = cand0;
    else if (req_load[cand1]) arb_id = cand1;
    else if (req_load[cand2]) arb_id = cand2;
    else                      arb_valid = 1'b0;
  end

  always_comb begin
    arb_addr = addr_wb;
    arb_len  = len_wb;
    case (arb_id)
      ID_IFMAP:  begin arb_addr = addr_ifmap;  arb_len = len_ifmap;  end
      ID_FILTER: begin arb_addr = addr_filter; arb_len = len_filter; end
      ID_BIAS:   begin arb_addr = addr_bias;   arb_len = len_bias;   end
      default:   begin arb_addr = addr_wb;     arb_len = len_wb;     end
    endcase
  end

  always_ff @(posedge core_clk or negedge core_reset) begin
    if (!core_reset) state <= IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (arb_valid) next_state = GRANT;
      GRANT:   next_state = (len_q == '0) ? DONE : SETUP;
      SETUP:   next_state = RUN;
      RUN:     if (issued == len_q) next_state = DRAIN;
      DRAIN:   if (drained == len_q) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign is_wb    = (grant_id == ID_WB);
  assign issue    = (state == RUN) && (issued < len_q) && !wfull;
  assign drain_en = ((state == RUN) || (state == DRAIN)) && (drained < len_q);

  // Grant data is captured on the IDLE->GRANT edge so GRANT can already test len.
  always_ff @(posedge core_clk or negedge core_reset) begin
    if (!core_reset) begin
      grant_id     <= ID_IFMAP;
      rr_ptr       <= ID_IFMAP;
      base_address <= '0;
      len_q        <= '0;
      issued       <= '0;
      drained      <= '0;
    end else begin
      if (state == IDLE && arb_valid) begin
        grant_id     <= arb_id;
        base_address <= arb_addr;
        len_q        <= arb_len;
        issued       <= '0;
        drained      <= '0;
      end else begin
        if (issue)                 issued  <= issued + 1'b1;
        if (drain_en && drain_ack) drained <= drained + 1'b1;
      end
      if (state == DONE && !is_wb) rr_ptr <= next_load(grant_id);
    end
  end

  always_comb begin
    busy             = (state != IDLE);
    direct_back_path = busy && is_wb;
    ifmap_bias       = busy && (grant_id == ID_IFMAP);
    ifmap_filter     = 2'b00;
    if (busy && grant_id == ID_FILTER) ifmap_filter = 2'b10;
    if (busy && grant_id == ID_BIAS)   ifmap_filter = 2'b01;
    transfer         = (state == SETUP);
    read_from_dram   = issue && !is_wb;
    read_from_glb    = issue && is_wb;
    rinc_to_glb      = drain_en && !is_wb;
    rinc_to_dram     = drain_en && is_wb;
    dram_w_en        = drain_en && is_wb;
    done_ifmap       = (state == DONE) && (grant_id == ID_IFMAP);
    done_filter      = (state == DONE) && (grant_id == ID_FILTER);
    done_bias        = (state == DONE) && (grant_id == ID_BIAS);
    done_wb          = (state == DONE) && (grant_id == ID_WB);
  end

endmodule

// File: tb/tb_fifo_transfer_scheduler.sv
// Directed bench for fifo_transfer_scheduler: one task per scenario with inline checks
// against hand-computed cycle counts and select values.
module tb_fifo_transfer_scheduler;
  localparam int AW = 20;
  localparam int LW = 16;

  logic core_clk = 1'b0;
  logic core_reset = 1'b1;
  logic req_ifmap = 0, req_filter = 0, req_bias = 0, req_wb = 0;
  logic [AW-1:0] addr_ifmap = '0, addr_filter = '0, addr_bias = '0, addr_wb = '0;
  logic [LW-1:0] len_ifmap = '0, len_filter = '0, len_bias = '0, len_wb = '0;
  logic wfull = 0, drain_ack = 0;
  logic done_ifmap, done_filter, done_bias, done_wb, direct_back_path, ifmap_bias;
  logic [1:0] ifmap_filter;
  logic [AW-1:0] base_address;
  logic transfer, read_from_dram, read_from_glb, rinc_to_glb, rinc_to_dram, dram_w_en, busy;
  logic [12:0] out_vec;

  fifo_transfer_scheduler #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .core_clk(core_clk), .core_reset(core_reset),
    .req_ifmap(req_ifmap), .req_filter(req_filter), .req_bias(req_bias), .req_wb(req_wb),
    .addr_ifmap(addr_ifmap), .addr_filter(addr_filter), .addr_bias(addr_bias), .addr_wb(addr_wb),
    .len_ifmap(len_ifmap), .len_filter(len_filter), .len_bias(len_bias), .len_wb(len_wb),
    .wfull(wfull), .drain_ack(drain_ack),
    .done_ifmap(done_ifmap), .done_filter(done_filter), .done_bias(done_bias), .done_wb(done_wb),
    .direct_back_path(direct_back_path), .ifmap_filter(ifmap_filter), .ifmap_bias(ifmap_bias),
    .base_address(base_address), .transfer(transfer),
    .read_from_dram(read_from_dram), .read_from_glb(read_from_glb),
    .rinc_to_glb(rinc_to_glb), .rinc_to_dram(rinc_to_dram), .dram_w_en(dram_w_en), .busy(busy)
  );

  assign out_vec = {done_ifmap, done_filter, done_bias, done_wb, direct_back_path, ifmap_bias,
                    transfer, read_from_dram, read_from_glb, rinc_to_glb, rinc_to_dram,
                    dram_w_en, busy};

  always #5 core_clk = ~core_clk;

  int compared = 0;
  int mismatched = 0;
  int cyc, req_cyc, xfer_cyc, done_cyc, ack_cyc, last_rd_cyc;
  int n_rd_dram, n_rd_glb, n_xfer, n_ack, n_stall_rd, n_path_bad, n_rinc_dram;
  int n_gap_bad, n_busy, n_dbp, n_sel_bad, order_code;
  int n_done [4];
  bit auto_drain, last_read, prev_done, check_sel;
  logic [1:0] exp_sel, xfer_sel;
  logic exp_ib, xfer_ib, xfer_dbp;
  logic [AW-1:0] xfer_addr;

  task automatic clear_counts();
    n_rd_dram = 0; n_rd_glb = 0; n_xfer = 0; n_ack = 0; n_stall_rd = 0; n_path_bad = 0;
    n_rinc_dram = 0; n_gap_bad = 0; n_busy = 0; n_dbp = 0; n_sel_bad = 0; order_code = 0;
    for (int i = 0; i < 4; i++) n_done[i] = 0;
    xfer_cyc = -1; done_cyc = -1; ack_cyc = -1; last_rd_cyc = -1;
    last_read = 0; prev_done = 0; check_sel = 0;
    xfer_sel = 2'b11; xfer_ib = 1'bx; xfer_dbp = 1'bx; xfer_addr = '1;
  endtask

  // One clock: drive inputs 1 time unit after the edge, observe 1 unit later.
  task automatic cycle(input bit wf, input bit force_ack);
    @(posedge core_clk); #1;
    cyc++;
    wfull = wf;
    drain_ack = (auto_drain & last_read) | force_ack;
    if (drain_ack) begin n_ack++; ack_cyc = cyc; end
    #1;
    if (read_from_dram) begin n_rd_dram++; last_rd_cyc = cyc; end
    if (read_from_glb) begin n_rd_glb++; last_rd_cyc = cyc; end
    last_read = read_from_dram | read_from_glb;
    if (transfer) begin
      n_xfer++; xfer_cyc = cyc; xfer_sel = ifmap_filter; xfer_ib = ifmap_bias;
      xfer_addr = base_address; xfer_dbp = direct_back_path;
    end
    if (wfull && (read_from_dram || read_from_glb)) n_stall_rd++;
    if (direct_back_path && (read_from_dram || rinc_to_glb)) n_path_bad++;
    if ((read_from_glb || rinc_to_dram || dram_w_en) && !direct_back_path) n_path_bad++;
    if (rinc_to_dram !== dram_w_en) n_path_bad++;
    if (rinc_to_dram) n_rinc_dram++;
    if (direct_back_path) n_dbp++;
    if (busy) n_busy++;
    if (check_sel && busy && (ifmap_filter !== exp_sel || ifmap_bias !== exp_ib)) n_sel_bad++;
    if (prev_done && busy) n_gap_bad++;
    prev_done = done_ifmap | done_filter | done_bias | done_wb;
    if (done_ifmap)  begin n_done[0]++; order_code = order_code * 4 + 0; done_cyc = cyc; req_ifmap = 0; end
    if (done_filter) begin n_done[1]++; order_code = order_code * 4 + 1; done_cyc = cyc; req_filter = 0; end
    if (done_bias)   begin n_done[2]++; order_code = order_code * 4 + 2; done_cyc = cyc; req_bias = 0; end
    if (done_wb)     begin n_done[3]++; order_code = order_code * 4 + 3; done_cyc = cyc; req_wb = 0; end
  endtask

  task automatic do_reset();
    core_reset = 0;
    req_ifmap = 0; req_filter = 0; req_bias = 0; req_wb = 0;
    wfull = 0; drain_ack = 0; auto_drain = 1;
    repeat (2) @(posedge core_clk);
    @(negedge core_clk);
    core_reset = 1;
    cyc = 0;
    clear_counts();
  endtask

  task automatic test_reset();
    #1 core_reset = 0;
    #3;
    compared++; if (out_vec !== 13'd0) begin mismatched++; $display("FAIL reset_outputs got=%b want=0", out_vec); end
    compared++; if (ifmap_filter !== 2'b00) begin mismatched++; $display("FAIL reset_sel got=%b want=00", ifmap_filter); end
    compared++; if (base_address !== '0) begin mismatched++; $display("FAIL reset_base got=%h want=0", base_address); end
    @(negedge core_clk);
    core_reset = 1; cyc = 0; auto_drain = 1;
    clear_counts();
    repeat (3) cycle(0, 0);
    compared++; if (n_busy !== 0) begin mismatched++; $display("FAIL idle_busy got=%0d want=0", n_busy); end
    compared++; if (n_xfer !== 0) begin mismatched++; $display("FAIL idle_transfer got=%0d want=0", n_xfer); end
  endtask

  task automatic test_ifmap_load();
    do_reset();
    addr_ifmap = 20'h00100; len_ifmap = 16'd4; req_ifmap = 1; req_cyc = cyc;
    for (int i = 0; i < 40 && n_done[0] == 0; i++) cycle(0, 0);
    repeat (3) cycle(0, 0);
    compared++; if (n_done[0] !== 1) begin mismatched++; $display("FAIL ifmap_done_count got=%0d want=1", n_done[0]); end
    compared++; if (n_xfer !== 1) begin mismatched++; $display("FAIL ifmap_transfer_count got=%0d want=1", n_xfer); end
    compared++; if (xfer_cyc !== req_cyc + 2) begin mismatched++; $display("FAIL ifmap_transfer_latency got=%0d want=%0d", xfer_cyc, req_cyc + 2); end
    compared++; if ({xfer_sel, xfer_ib, xfer_dbp} !== 4'b0010) begin mismatched++; $display("FAIL ifmap_selects got=%b want=0010", {xfer_sel, xfer_ib, xfer_dbp}); end
    compared++; if (xfer_addr !== 20'h00100) begin mismatched++; $display("FAIL ifmap_base got=%h want=00100", xfer_addr); end
    compared++; if (n_rd_dram !== 4 || n_rd_glb !== 0) begin mismatched++; $display("FAIL ifmap_reads got=%0d/%0d want=4/0", n_rd_dram, n_rd_glb); end
    compared++; if (done_cyc !== req_cyc + 9) begin mismatched++; $display("FAIL ifmap_done_cycle got=%0d want=%0d", done_cyc, req_cyc + 9); end
    compared++; if (done_cyc !== ack_cyc + 2) begin mismatched++; $display("FAIL ifmap_done_after_ack got=%0d want=%0d", done_cyc, ack_cyc + 2); end
  endtask

  task automatic test_filter_stall();
    do_reset();
    addr_filter = 20'h2A000; len_filter = 16'd8; req_filter = 1; req_cyc = cyc;
    for (int i = 0; i < 60 && n_done[1] == 0; i++) cycle((cyc >= 4 && cyc <= 6), 0);
    repeat (2) cycle(0, 0);
    compared++; if (n_stall_rd !== 0) begin mismatched++; $display("FAIL stall_reads got=%0d want=0", n_stall_rd); end
    compared++; if (n_rd_dram !== 8) begin mismatched++; $display("FAIL filter_reads got=%0d want=8", n_rd_dram); end
    compared++; if (last_rd_cyc !== req_cyc + 13) begin mismatched++; $display("FAIL filter_last_read got=%0d want=%0d", last_rd_cyc, req_cyc + 13); end
    compared++; if (n_done[1] !== 1) begin mismatched++; $display("FAIL filter_done_count got=%0d want=1", n_done[1]); end
    compared++; if (done_cyc !== ack_cyc + 2) begin mismatched++; $display("FAIL filter_done_after_ack got=%0d want=%0d", done_cyc, ack_cyc + 2); end
    compared++; if ({xfer_sel, xfer_ib} !== 3'b100) begin mismatched++; $display("FAIL filter_selects got=%b want=100", {xfer_sel, xfer_ib}); end
  endtask

  task automatic test_priority();
    do_reset();
    addr_wb = 20'h0F000; len_wb = 16'd3;
    addr_ifmap = 20'h00010; len_ifmap = 16'd2;
    addr_filter = 20'h00020; len_filter = 16'd2;
    addr_bias = 20'h00030; len_bias = 16'd2;
    req_wb = 1; req_ifmap = 1; req_filter = 1; req_bias = 1;
    for (int i = 0; i < 200 && (n_done[0] + n_done[1] + n_done[2] + n_done[3]) < 4; i++) cycle(0, 0);
    repeat (3) cycle(0, 0);
    compared++; if (order_code !== 198) begin mismatched++; $display("FAIL service_order got=%0d want=198 (wb,ifmap,filter,bias)", order_code); end
    compared++; if ({n_done[0], n_done[1], n_done[2], n_done[3]} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      mismatched++; $display("FAIL done_counts got=%0d,%0d,%0d,%0d want=1,1,1,1", n_done[0], n_done[1], n_done[2], n_done[3]);
    end
    compared++; if (n_rd_glb !== 3 || n_rd_dram !== 6) begin mismatched++; $display("FAIL mixed_reads got glb=%0d dram=%0d want 3/6", n_rd_glb, n_rd_dram); end
    compared++; if (n_rinc_dram !== 4) begin mismatched++; $display("FAIL wb_rinc_cycles got=%0d want=4", n_rinc_dram); end
    compared++; if (n_dbp !== 8) begin mismatched++; $display("FAIL wb_path_cycles got=%0d want=8", n_dbp); end
    compared++; if (n_path_bad !== 0) begin mismatched++; $display("FAIL path_consistency got=%0d want=0", n_path_bad); end
    compared++; if (n_gap_bad !== 0) begin mismatched++; $display("FAIL idle_gap got=%0d want=0", n_gap_bad); end
  endtask

  task automatic test_zero_len();
    do_reset();
    addr_bias = 20'h00ABC; len_bias = 16'd0;
    check_sel = 1; exp_sel = 2'b01; exp_ib = 0;
    req_bias = 1; req_cyc = cyc;
    for (int i = 0; i < 20 && n_done[2] == 0; i++) cycle(0, 0);
    repeat (2) cycle(0, 0);
    compared++; if (n_done[2] !== 1) begin mismatched++; $display("FAIL zero_done_count got=%0d want=1", n_done[2]); end
    compared++; if (done_cyc !== req_cyc + 2) begin mismatched++; $display("FAIL zero_done_cycle got=%0d want=%0d", done_cyc, req_cyc + 2); end
    compared++; if (n_xfer !== 0) begin mismatched++; $display("FAIL zero_transfer got=%0d want=0", n_xfer); end
    compared++; if (n_rd_dram + n_rd_glb !== 0) begin mismatched++; $display("FAIL zero_reads got=%0d want=0", n_rd_dram + n_rd_glb); end
    compared++; if (n_sel_bad !== 0) begin mismatched++; $display("FAIL zero_selects got=%0d want=0", n_sel_bad); end
    compared++; if (n_busy !== 2) begin mismatched++; $display("FAIL zero_busy_cycles got=%0d want=2", n_busy); end
  endtask

  task automatic test_reset_mid();
    int bad_in_reset;
    bad_in_reset = 0;
    do_reset();
    addr_filter = 20'h3C000; len_filter = 16'd8; req_filter = 1;
    for (int i = 0; i < 30 && n_rd_dram < 3; i++) cycle(0, 0);
    compared++; if (n_rd_dram !== 3 || n_done[1] !== 0) begin mismatched++; $display("FAIL mid_pre_reset reads=%0d done=%0d want 3/0", n_rd_dram, n_done[1]); end
    #2 core_reset = 0; drain_ack = 0;
    #1;
    compared++; if (out_vec !== 13'd0 || ifmap_filter !== 2'b00 || base_address !== '0) begin
      mismatched++; $display("FAIL mid_async_reset got=%b sel=%b base=%h want all 0", out_vec, ifmap_filter, base_address);
    end
    repeat (2) begin @(posedge core_clk); #1; if (out_vec !== 13'd0) bad_in_reset++; end
    compared++; if (bad_in_reset !== 0) begin mismatched++; $display("FAIL mid_held_reset got=%0d want=0", bad_in_reset); end
    @(negedge core_clk);
    core_reset = 1; cyc = 0; req_cyc = 0;
    clear_counts();
    for (int i = 0; i < 60 && n_done[1] == 0; i++) cycle(0, 0);
    compared++; if (n_xfer !== 1 || xfer_cyc !== req_cyc + 2) begin mismatched++; $display("FAIL restart_transfer got=%0d@%0d want=1@2", n_xfer, xfer_cyc); end
    compared++; if (n_rd_dram !== 8) begin mismatched++; $display("FAIL restart_reads got=%0d want=8", n_rd_dram); end
    compared++; if (n_done[1] !== 1) begin mismatched++; $display("FAIL restart_done got=%0d want=1", n_done[1]); end
  endtask

  task automatic test_extra_ack();
    logic busy6, rinc6, busy8;
    busy6 = 0; rinc6 = 1; busy8 = 1;
    do_reset();
    auto_drain = 0;
    addr_ifmap = 20'h00200; len_ifmap = 16'd2; req_ifmap = 1;
    for (int i = 0; i < 12; i++) begin
      cycle(0, (cyc + 1 >= 4 && cyc + 1 <= 6));
      if (cyc == 6) begin busy6 = busy; rinc6 = rinc_to_glb; end
      if (cyc == 8) busy8 = busy;
    end
    compared++; if (n_ack !== 3) begin mismatched++; $display("FAIL extra_ack_count got=%0d want=3", n_ack); end
    compared++; if (n_rd_dram !== 2) begin mismatched++; $display("FAIL extra_reads got=%0d want=2", n_rd_dram); end
    compared++; if ({busy6, rinc6} !== 2'b10) begin mismatched++; $display("FAIL extra_drain_state got=%b want=10", {busy6, rinc6}); end
    compared++; if (n_done[0] !== 1 || done_cyc !== 7) begin mismatched++; $display("FAIL extra_done got=%0d@%0d want=1@7", n_done[0], done_cyc); end
    compared++; if (busy8 !== 1'b0) begin mismatched++; $display("FAIL extra_idle got=%b want=0", busy8); end
  endtask

  initial begin
    auto_drain = 1;
    cyc = 0;
    clear_counts();
    test_reset();
    test_ifmap_load();
    test_filter_stall();
    test_priority();
    test_zero_len();
    test_reset_mid();
    test_extra_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
